// File: rtl/operand_entry_bcd.sv
// Keypad operand accumulator: builds an unsigned operand from decimal key codes and holds it until it is consumed.
// Build option LOG_ZERO_GUARD_EN: an Enter with a zero operand is rejected and pulses err.
//
// state | meaning
// EMPTY | no digits entered (count == 0)
// ENTRY | one or more digits entered
// HOLD  | operand presented on num/num_valid; keys stalled
module operand_entry_bcd #(
  parameter int NUM_W      = 10,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [NUM_W-1:0] num,
  output logic             num_valid,
  input  logic             num_ready,
  output logic [2:0]       digit_count,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {EMPTY, ENTRY, HOLD} state_t;

  localparam logic [NUM_W+3:0] MAX_VAL = {4'b0, {NUM_W{1'b1}}};
  localparam logic [2:0]       MAX_CNT = 3'(MAX_DIGITS);

  state_t           state;
  logic [NUM_W-1:0] acc;
  logic [2:0]       count;
  logic [NUM_W+3:0] next_val;
  logic             is_digit;
  logic             zero_reject;

  // Four spare bits keep acc*10+d from wrapping before the range compare.
  assign next_val  = {4'b0, acc} * (NUM_W+4)'(10) + (NUM_W+4)'(key_code);
  assign is_digit  = (key_code < 4'd10);
  assign key_ready = (state != HOLD);
  assign digit_count = count;

`ifdef LOG_ZERO_GUARD_EN
  assign zero_reject = (acc == '0);
`else
  assign zero_reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      acc       <= '0;
      count     <= '0;
      num       <= '0;
      num_valid <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      ovf <= 1'b0;
      err <= 1'b0;
      case (state)
        EMPTY, ENTRY: begin
          if (key_valid) begin
            if (is_digit) begin
              if (count == MAX_CNT || next_val > MAX_VAL) begin
                ovf <= 1'b1;
              end else begin
                acc   <= next_val[NUM_W-1:0];
                count <= count + 3'd1;
                state <= ENTRY;
              end
            end else begin
              case (key_code)
                4'hA: begin
                  acc   <= '0;
                  count <= '0;
                  state <= EMPTY;
                end
                4'hB: begin
                  if (count != 3'd0) begin
                    acc   <= acc / NUM_W'(10);
                    count <= count - 3'd1;
                    if (count == 3'd1) state <= EMPTY;
                  end
                end
                4'hE: begin
                  if (zero_reject) begin
                    err   <= 1'b1;
                    acc   <= '0;
                    count <= '0;
                    state <= EMPTY;
                  end else begin
                    num       <= acc;
                    num_valid <= 1'b1;
                    state     <= HOLD;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        HOLD: begin
          // num keeps its last value after the handshake
          if (num_ready) begin
            num_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
